// File: rtl/ysyx_220066_issue_ctrl.sv
// Issue controller: 32-entry register scoreboard plus mul/div busy sequencer between ID and EX.
// Latency: issue/block are combinational from ID fields; scoreboard and busy counter update on the next edge.
// Backpressure: block holds IF/ID on RAW/WAW, mul/div occupancy, or error drain; flush kills ID without stalling.
module ysyx_220066_issue_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic        id_rs1_en,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs2_en,
  input  logic [4:0]  id_rd,
  input  logic        id_regwr,
  input  logic        id_is_multi,
  input  logic        id_is_div,
  input  logic        id_error,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwr,
  output logic        issue,
  output logic        block,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_done,
  output logic [1:0]  stall_cause,
  output logic [31:0] pending
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_HAZ   = 2'd1;
  localparam logic [1:0] CAUSE_MD    = 2'd2;
  localparam logic [1:0] CAUSE_DRAIN = 2'd3;

  logic [CNT_W-1:0] md_cnt;
  logic [31:0]      pending_nxt;
  logic             raw_hit;
  logic             waw_hit;
  logic             md_op;
  logic             md_conflict;
  logic             drain_wait;
  logic             sb_set;
  logic             sb_clr;

  // Hazard detection against registered scoreboard only (no writeback bypass)
  always_comb begin
    raw_hit     = (id_rs1_en && (id_rs1 != 5'd0) && pending[id_rs1]) ||
                  (id_rs2_en && (id_rs2 != 5'd0) && pending[id_rs2]);
    waw_hit     = id_regwr && (id_rd != 5'd0) && pending[id_rd];
    md_busy     = (md_cnt != '0);
    md_done     = (md_cnt == CNT_W'(1));
    md_op       = id_is_multi || id_is_div;
    md_conflict = md_op && md_busy;
    // An illegal instruction waits for every older instruction to finish so the trap is precise
    drain_wait  = id_error && ((pending != 32'd0) || md_busy);
  end

  // Issue/stall decision; flush overrides everything
  always_comb begin
    issue       = 1'b0;
    block       = 1'b0;
    md_start    = 1'b0;
    stall_cause = CAUSE_NONE;
    if (id_valid && !flush) begin
      if (id_error) issue = !drain_wait;
      else          issue = !(raw_hit || waw_hit || md_conflict);
      block    = !issue;
      md_start = issue && md_op && !id_error;
      if (block) begin
        if (drain_wait)              stall_cause = CAUSE_DRAIN;
        else if (raw_hit || waw_hit) stall_cause = CAUSE_HAZ;
        else if (md_conflict)        stall_cause = CAUSE_MD;
        else                         stall_cause = CAUSE_NONE;
      end
    end
  end

  // Next scoreboard value: clear on retire, then set on issue so a same-index set wins
  always_comb begin
    sb_set      = issue && id_regwr && (id_rd != 5'd0);
    sb_clr      = wb_valid && wb_regwr && (wb_rd != 5'd0);
    pending_nxt = pending;
    if (sb_clr) pending_nxt[wb_rd] = 1'b0;
    if (sb_set) pending_nxt[id_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= 32'd0;
    else      pending <= pending_nxt;
  end

  // Mul/div busy counter: load latency on start, count down to idle; divide wins if both flagged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_cnt <= '0;
    end else if (md_start) begin
      md_cnt <= id_is_div ? DIV_CNT : MUL_CNT;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_220066_issue_ctrl.sv
// Directed testbench for the ID/EX issue controller.
// Drives inputs 1 time unit after the rising edge and samples 1 unit later.
// Covers reset, RAW/WAW, x0, mul/div sequencing, error drain, flush, set/clear race, async reset.
module tb_ysyx_220066_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic        id_rs1_en;
  logic [4:0]  id_rs2;
  logic        id_rs2_en;
  logic [4:0]  id_rd;
  logic        id_regwr;
  logic        id_is_multi;
  logic        id_is_div;
  logic        id_error;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_regwr;
  logic        issue;
  logic        block;
  logic        md_start;
  logic        md_busy;
  logic        md_done;
  logic [1:0]  stall_cause;
  logic [31:0] pending;

  int n_chk;
  int n_err;

  ysyx_220066_issue_ctrl #(.MUL_LAT(3), .DIV_LAT(33), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_en(id_rs1_en),
    .id_rs2(id_rs2), .id_rs2_en(id_rs2_en), .id_rd(id_rd), .id_regwr(id_regwr),
    .id_is_multi(id_is_multi), .id_is_div(id_is_div), .id_error(id_error),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
    .issue(issue), .block(block), .md_start(md_start), .md_busy(md_busy),
    .md_done(md_done), .stall_cause(stall_cause), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    id_valid = 0; id_rs1 = 0; id_rs1_en = 0; id_rs2 = 0; id_rs2_en = 0;
    id_rd = 0; id_regwr = 0; id_is_multi = 0; id_is_div = 0; id_error = 0;
    flush = 0; wb_valid = 0; wb_rd = 0; wb_regwr = 0;
  endtask

  // Present an instruction in ID (all other control inputs cleared)
  task automatic instr(input logic [4:0] rs1, input logic rs1_en, input logic [4:0] rs2,
                       input logic rs2_en, input logic [4:0] rd, input logic regwr,
                       input logic mul, input logic div, input logic err);
    clr_inputs();
    id_valid = 1; id_rs1 = rs1; id_rs1_en = rs1_en; id_rs2 = rs2; id_rs2_en = rs2_en;
    id_rd = rd; id_regwr = regwr; id_is_multi = mul; id_is_div = div; id_error = err;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1; wb_regwr = 1; wb_rd = rd;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    clr_inputs();
    #3;
    chk("rst_pending", pending, 32'd0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_done", {31'd0, md_done}, 32'd0);
    chk("rst_issue_block", {30'd0, issue, block}, 32'd0);

    // Release reset between edges and present a hazard-free reader of x5
    #9;
    rst = 1'b1;
    instr(5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    #1;
    chk("first_issue", {31'd0, issue}, 32'd1);
    chk("first_block", {31'd0, block}, 32'd0);
    chk("first_cause", {30'd0, stall_cause}, 32'd0);

    // RAW/WAW on x5
    instr(5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0);
    #1;
    chk("wr5_issue", {31'd0, issue}, 32'd1);
    step();
    chk("pending5_set", pending, 32'h0000_0020);
    instr(5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    #1;
    chk("raw1_block", {31'd0, block}, 32'd1);
    chk("raw1_cause", {30'd0, stall_cause}, 32'd1);
    chk("raw1_issue", {31'd0, issue}, 32'd0);
    instr(5'd0, 0, 5'd5, 1, 5'd0, 0, 0, 0, 0);
    #1;
    chk("raw2_block", {31'd0, block}, 32'd1);
    instr(5'd5, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0);
    #1;
    chk("waw_cause", {30'd0, stall_cause}, 32'd1);
    instr(5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    wb(5'd5);
    #1;
    chk("no_bypass_block", {31'd0, block}, 32'd1);
    step();
    wb_valid = 0; wb_regwr = 0;
    #1;
    chk("pending5_clr", pending, 32'd0);
    chk("raw_release_issue", {31'd0, issue}, 32'd1);

    // Writes to x0 never mark the scoreboard
    instr(5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0);
    #1;
    chk("x0_wr_issue", {31'd0, issue}, 32'd1);
    step();
    chk("x0_pending", pending, 32'd0);
    instr(5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0);
    #1;
    chk("x0_read_issue", {31'd0, issue}, 32'd1);

    // Divide: 33 busy cycles, then a queued multiply issues the cycle after md_done
    instr(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
    #1;
    chk("div_start", {31'd0, md_start}, 32'd1);
    step();
    instr(5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
    #1;
    chk("div_start_pulse", {31'd0, md_start}, 32'd0);
    chk("mul_wait_cause", {30'd0, stall_cause}, 32'd2);
    for (int k = 1; k <= 33; k++) begin
      if (k > 1) step();
      chk("div_busy", {31'd0, md_busy}, 32'd1);
      chk("div_done", {31'd0, md_done}, (k == 33) ? 32'd1 : 32'd0);
      chk("mul_blocked", {31'd0, block}, 32'd1);
    end
    step();
    chk("div_idle", {31'd0, md_busy}, 32'd0);
    chk("mul_issue", {31'd0, issue}, 32'd1);
    chk("mul_start", {31'd0, md_start}, 32'd1);
    chk("mul_cause", {30'd0, stall_cause}, 32'd0);
    step();
    clr_inputs();
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) step();
      chk("mul_busy", {31'd0, md_busy}, 32'd1);
      chk("mul_done", {31'd0, md_done}, (k == 3) ? 32'd1 : 32'd0);
    end
    step();
    chk("mul_idle", {31'd0, md_busy}, 32'd0);

    // Error drain behind pending x7; the error carries a mul flag that must not start the unit
    instr(5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 0);
    #1;
    chk("wr7_issue", {31'd0, issue}, 32'd1);
    step();
    instr(5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1);
    #1;
    chk("err_block", {31'd0, block}, 32'd1);
    chk("err_cause", {30'd0, stall_cause}, 32'd3);
    wb(5'd7);
    #1;
    chk("err_still_block", {31'd0, block}, 32'd1);
    step();
    wb_valid = 0; wb_regwr = 0;
    #1;
    chk("err_issue", {31'd0, issue}, 32'd1);
    chk("err_no_md_start", {31'd0, md_start}, 32'd0);

    // Flush during a RAW stall: no issue, no block, no scoreboard set
    instr(5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0, 0);
    step();
    chk("pending9_set", pending, 32'h0000_0200);
    instr(5'd9, 1, 5'd0, 0, 5'd4, 1, 0, 0, 0);
    #1;
    chk("raw9_block", {31'd0, block}, 32'd1);
    flush = 1;
    #1;
    chk("flush_issue_block", {30'd0, issue, block}, 32'd0);
    chk("flush_cause", {30'd0, stall_cause}, 32'd0);
    step();
    chk("flush_no_set", pending, 32'h0000_0200);

    // Set and clear of x9 on the same edge: set wins
    clr_inputs();
    wb(5'd9);
    step();
    chk("pending9_clr", pending, 32'd0);
    instr(5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0, 0);
    wb(5'd9);
    #1;
    chk("race_issue", {31'd0, issue}, 32'd1);
    step();
    chk("race_set_wins", pending, 32'h0000_0200);

    // Asynchronous reset mid multiply
    instr(5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
    #1;
    chk("mul2_start", {31'd0, md_start}, 32'd1);
    step();
    clr_inputs();
    #1;
    chk("mul2_busy", {31'd0, md_busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, md_busy}, 32'd0);
    chk("arst_pending", pending, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
